// File: rtl/equiv_vector_sequencer.sv
// Sequences LFSR-driven equivalence vectors into golden/synthesized datapath copies and tallies mismatches.
// Optional EQUIV_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module equiv_vector_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16,
    parameter int Y_W           = 82
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [63:0]      seed,
    input  logic [Y_W-1:0]   y_ref,
    input  logic [Y_W-1:0]   y_dut,
    output logic [10:0]      op0_o,
    output logic [11:0]      op1_o,
    output logic [9:0]       op2_o,
    output logic [8:0]       op3_o,
    output logic [10:0]      op4_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [CNT_W-1:0] vec_idx
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t           state, state_next;
    logic [3:0]       settle_cnt;
    logic [63:0]      lfsr;
    logic [63:0]      lfsr_step;
    logic [CNT_W-1:0] num_vec;
    logic [CNT_W-1:0] count_next;
    logic             mismatch;
    logic             last_vec;
    logic             stop_now;

    assign mismatch   = (y_ref != y_dut);
    assign last_vec   = (vec_idx == num_vec - 1'b1);
    assign count_next = (mismatch && mismatch_count != ALL_ONES) ? mismatch_count + 1'b1 : mismatch_count;
    // Fibonacci taps 64,63,61,60; feedback enters at bit 0
    assign lfsr_step  = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};

`ifdef EQUIV_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_vectors == '0) ? FIN : DRIVE;
                end
            end
            DRIVE: begin
                busy       = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = (last_vec || stop_now) ? FIN : DRIVE;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr           <= 64'h1;
            num_vec        <= '0;
            settle_cnt     <= '0;
            op0_o          <= '0;
            op1_o          <= '0;
            op2_o          <= '0;
            op3_o          <= '0;
            op4_o          <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= ALL_ONES;
            vec_idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_vec        <= num_vectors;
                        lfsr           <= (seed == 64'h0) ? 64'h1 : seed;
                        mismatch_count <= '0;
                        // An empty run is trivially clean, so pass is already valid at its FIN
                        pass           <= (num_vectors == '0);
                        first_fail_idx <= ALL_ONES;
                        vec_idx        <= '0;
                    end
                end
                DRIVE: begin
                    op0_o      <= lfsr[10:0];
                    op1_o      <= lfsr[22:11];
                    op2_o      <= lfsr[32:23];
                    op3_o      <= lfsr[41:33];
                    op4_o      <= lfsr[52:42];
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                CHECK: begin
                    mismatch_count <= count_next;
                    if (mismatch && first_fail_idx == ALL_ONES) begin
                        first_fail_idx <= vec_idx;
                    end
                    lfsr <= lfsr_step;
                    if (state_next == FIN) begin
                        pass <= (count_next == '0);
                    end else begin
                        vec_idx <= vec_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_equiv_vector_sequencer.sv
// Directed bench for equiv_vector_sequencer: per-cycle comparison against an expected-timeline model plus literal checks.
module tb_equiv_vector_sequencer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vectors = '0;
    logic [63:0] seed = '0;
    logic [81:0] y_ref = '0;
    logic [81:0] y_dut = '0;
    logic [10:0] op0_o;
    logic [11:0] op1_o;
    logic [9:0]  op2_o;
    logic [8:0]  op3_o;
    logic [10:0] op4_o;
    logic        busy, done, pass;
    logic [15:0] mismatch_count, first_fail_idx, vec_idx;

    equiv_vector_sequencer #(.SETTLE_CYCLES(S), .CNT_W(16), .Y_W(82)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors), .seed(seed),
        .y_ref(y_ref), .y_dut(y_dut),
        .op0_o(op0_o), .op1_o(op1_o), .op2_o(op2_o), .op3_o(op3_o), .op4_o(op4_o),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy, done, pass, inj;
        logic [15:0] mm, ffi, vidx;
        logic [10:0] op0;
        logic [11:0] op1;
        logic [9:0]  op2;
        logic [8:0]  op3;
        logic [10:0] op4;
    } exp_t;

    exp_t exp_q[$];
    exp_t idle_exp;
    bit   bad [0:15];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void reset_exp();
        idle_exp.busy = 1'b0; idle_exp.done = 1'b0; idle_exp.pass = 1'b0; idle_exp.inj = 1'b0;
        idle_exp.mm = '0; idle_exp.ffi = 16'hFFFF; idle_exp.vidx = '0;
        idle_exp.op0 = '0; idle_exp.op1 = '0; idle_exp.op2 = '0; idle_exp.op3 = '0; idle_exp.op4 = '0;
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        logic fb;
        fb = x[63] ^ x[62] ^ x[60] ^ x[59];
        return {x[62:0], fb};
    endfunction

    // Expected DUT state for each cycle after an accepted start, vector by vector
    function automatic void build_run(input logic [63:0] sd, input int n);
        exp_t        e;
        logic [63:0] l;
        int          mm;
        int          ffi;
        bit          stop;
        e = idle_exp;
        e.done = 1'b0; e.pass = 1'b0; e.inj = 1'b0;
        e.vidx = '0;
        mm = 0; ffi = 16'hFFFF;
        l = (sd == 64'h0) ? 64'h1 : sd;
        stop = 1'b0;
        for (int i = 0; i < n && !stop; i++) begin
            e.busy = 1'b1; e.vidx = 16'(i); e.mm = 16'(mm); e.ffi = 16'(ffi); e.inj = bad[i];
            exp_q.push_back(e);
            e.op0 = l[10:0]; e.op1 = l[22:11]; e.op2 = l[32:23]; e.op3 = l[41:33]; e.op4 = l[52:42];
            for (int k = 0; k < S + 1; k++) exp_q.push_back(e);
            if (bad[i]) begin
                if (mm < 16'hFFFF) mm++;
                if (ffi == 16'hFFFF) ffi = i;
`ifdef EQUIV_STOP_ON_FAIL_EN
                stop = 1'b1;
`endif
            end
            l = lfsr_next(l);
        end
        e.busy = 1'b0; e.done = 1'b1; e.inj = 1'b0;
        e.mm = 16'(mm); e.ffi = 16'(ffi); e.pass = (mm == 0);
        exp_q.push_back(e);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.done) begin
                    idle_exp = e;
                    idle_exp.done = 1'b0;
                end
            end else begin
                e = idle_exp;
            end
            chk("busy", 64'(busy), 64'(e.busy));
            chk("done", 64'(done), 64'(e.done));
            chk("pass", 64'(pass), 64'(e.pass));
            chk("mismatch_count", 64'(mismatch_count), 64'(e.mm));
            chk("first_fail_idx", 64'(first_fail_idx), 64'(e.ffi));
            chk("vec_idx", 64'(vec_idx), 64'(e.vidx));
            chk("op0", 64'(op0_o), 64'(e.op0));
            chk("op1", 64'(op1_o), 64'(e.op1));
            chk("op2", 64'(op2_o), 64'(e.op2));
            chk("op3", 64'(op3_o), 64'(e.op3));
            chk("op4", 64'(op4_o), 64'(e.op4));
            y_dut = e.inj ? (y_ref ^ (82'd1 << 40)) : y_ref;
        end
    end

    task automatic do_start(input logic [63:0] sd, input int n);
        @(negedge clk);
        #1;
        seed = sd;
        num_vectors = 16'(n);
        y_ref = {18'($urandom), $urandom, $urandom};
        start = 1'b1;
        build_run(sd, n);
        for (int i = 0; i < 16; i++) bad[i] = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busy_seen);
        lat = 0;
        busy_seen = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, required done within 300 cycles");
        end
    endtask

    initial begin
        int lat;
        bit bs;
        reset_exp();
        for (int i = 0; i < 16; i++) bad[i] = 1'b0;

        // Reset with random inputs
        rst_n = 1'b0;
        start = 1'($urandom);
        seed = {$urandom, $urandom};
        num_vectors = 16'($urandom);
        y_ref = {18'($urandom), $urandom, $urandom};
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ffi", 64'(first_fail_idx), 64'hFFFF);
        chk("rst_op0", 64'(op0_o), 64'd0);
        #1;
        start = 1'b0;
        rst_n = 1'b1;

        // Operand mapping
        do_start(64'hABCD, 1);
        wait_done(lat, bs);
        chk("map_latency", 64'(lat), 64'd5);
        chk("map_op0", 64'(op0_o), 64'h3CD);
        chk("map_op1", 64'(op1_o), 64'h015);
        chk("map_op2", 64'(op2_o), 64'h0);
        chk("map_op3", 64'(op3_o), 64'h0);
        chk("map_op4", 64'(op4_o), 64'h0);
        chk("map_pass", 64'(pass), 64'd1);
        chk("map_mm", 64'(mismatch_count), 64'd0);

        // Mismatch on vector 3 only
        bad[3] = 1'b1;
        do_start(64'h1234_5678_9ABC_DEF0, 8);
        wait_done(lat, bs);
        chk("mm_count", 64'(mismatch_count), 64'd1);
        chk("mm_ffi", 64'(first_fail_idx), 64'd3);
        chk("mm_pass", 64'(pass), 64'd0);
        chk("mm_vec_idx", 64'(vec_idx), 64'd7);

        // Zero vectors
        do_start(64'h77, 0);
        wait_done(lat, bs);
        chk("zero_latency", 64'(lat), 64'd1);
        chk("zero_pass", 64'(pass), 64'd1);
        chk("zero_busy_seen", 64'(bs), 64'd0);

        // Zero seed behaves as seed 1
        do_start(64'h0, 1);
        wait_done(lat, bs);
        chk("seed0_op0", 64'(op0_o), 64'd1);
        chk("seed0_op1", 64'(op1_o), 64'd0);

        // Start during SETTLE of vector 2 is ignored
        do_start(64'hDEAD_BEEF_0123_4567, 4);
        repeat (10) @(negedge clk);
        #1;
        seed = 64'h5555;
        num_vectors = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bs);
        chk("ignored_start_latency", 64'(lat), 64'd7);
        chk("ignored_start_vec_idx", 64'(vec_idx), 64'd3);

        // Reset mid-run
        do_start(64'h42, 6);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        reset_exp();
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mismatches at vectors 2 and 5
        bad[2] = 1'b1;
        bad[5] = 1'b1;
        do_start(64'hFEED, 8);
        wait_done(lat, bs);
        chk("stop_pass", 64'(pass), 64'd0);
        chk("stop_ffi", 64'(first_fail_idx), 64'd2);
`ifdef EQUIV_STOP_ON_FAIL_EN
        chk("stop_mm", 64'(mismatch_count), 64'd1);
        chk("stop_vec_idx", 64'(vec_idx), 64'd2);
        chk("stop_latency", 64'(lat), 64'd13);
`else
        chk("stop_mm", 64'(mismatch_count), 64'd2);
        chk("stop_vec_idx", 64'(vec_idx), 64'd7);
        chk("stop_latency", 64'(lat), 64'd33);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
